spi_byte_receiver: RTL and testbench
====================================

// Module: spi_byte_receiver
// PURPOSE
//  SPI peripheral-side front end (mode 0) feeding spi_decoder. Synchronises external SCLK/CS_n/MOSI
//  into clk, deserialises MSB-first bytes, emits a 1-cycle data_valid pulse per byte with RX_Count.
//  Serialises the decoder's tx_byte onto MISO. Sits between the SPI pads and spi_decoder.
// PARAMETERS
//  MAX_BYTES_PER_CS  2  max bytes accepted per CS_n-low frame; must match spi_decoder
//  SYNC_STAGES       2  metastability flops on SCLK/CS_n/MOSI (>=2)
// PORTS
//  clk         in   1  system clock; must be >= 4x SCLK frequency
//  rst         in   1  asynchronous, active-high reset
//  i_spi_sclk  in   1  SPI clock from controller (async)
//  i_spi_cs_n  in   1  SPI chip select, active low (async)
//  i_spi_mosi  in   1  SPI data in (async)
//  o_spi_miso  out  1  SPI data out
//  tx_byte     in   8  byte to shift out on MISO for the next byte slot (from spi_decoder)
//  data_valid  out  1  1-cycle pulse: rx_byte/RX_Count valid
//  RX_Count    out  $clog2(MAX_BYTES_PER_CS+1)  bytes completed in current frame incl. this one
//  rx_byte     out  8  last received byte
// BEHAVIOUR
//  Reset: data_valid=0, RX_Count=0, rx_byte=8'h00, o_spi_miso=0, state=IDLE, sync flops to idle
//   (SCLK=0, CS_n=1, MOSI=0); rst may assert at any time and aborts the frame with no pulse.
//  Sync: SYNC_STAGES flops per input, plus one history flop for edge detect (rise/fall of SCLK, fall/rise of CS_n).
//  FSM: IDLE -> SHIFT on CS_n fall: bit_cnt=0, RX_Count=0, load tx shift reg from tx_byte, MISO=tx_byte[7].
//   SHIFT: on SCLK rise, shift MOSI into rx_shift (MSB first), bit_cnt++.
//    on 8th rise: rx_byte<=assembled byte, data_valid=1 next cycle, RX_Count++, bit_cnt=0;
//    if RX_Count reaches MAX_BYTES_PER_CS -> HOLD, else reload tx shift reg from tx_byte.
//    on SCLK fall: MISO <= next tx bit (falling edge after 8th rise presents new byte's MSB).
//   HOLD: further SCLK edges ignored, MISO=0, no pulses.
//   Any state: CS_n rise -> IDLE; partial byte (bit_cnt!=0) discarded, no pulse; RX_Count/rx_byte hold.
//  Latency: data_valid asserts SYNC_STAGES+1 clk cycles after 8th SCLK rising edge at the pin.
//  data_valid is exactly 1 cycle wide; never asserted in IDLE or HOLD.
//  CS_n fall and SCLK rise detected in same cycle: frame start applies first, the edge is not sampled.
//  RX_Count saturates at MAX_BYTES_PER_CS; width rule: no wrap.
// CONFIGURATION
//  SPI_OVERRUN_DETECT_EN defined: extra port o_overrun (out,1), reset 0; 1-cycle pulse on each
//   completed 8th SCLK rise while in HOLD (bytes beyond MAX_BYTES_PER_CS). HOLD still drops data.
//  Not defined: port absent, excess bytes silently dropped; all other behaviour identical.
// STRUCTURE
//  Shared package spi_pkg: state enum {IDLE,SHIFT,HOLD}, BITS_PER_BYTE=8, RX_COUNT_W function
//   ($clog2(MAX_BYTES_PER_CS+1)), shared with spi_decoder.
//  One sub-module: spi_input_sync (SYNC_STAGES-deep synchroniser + rise/fall detect), instantiated
//   for SCLK and CS_n; MOSI uses its plain synchronised output only.
// TESTING
//  1. Reset, CS_n low, send 8'hAA then 8'h6A, CS_n high -> two data_valid pulses, rx_byte AA/RX_Count=1,
//     then 6A/RX_Count=2; pulse SYNC_STAGES+1 cycles after each 8th SCLK rise.
//  2. tx_byte=8'hC3 before CS_n fall, 8'h5A before 2nd byte -> MISO bits sampled on SCLK rise = C3, 5A.
//  3. Send 3 bytes in one frame (MAX=2) -> 2 pulses only, RX_Count stays 2; with SPI_OVERRUN_DETECT_EN
//     o_overrun pulses once after 3rd byte.
//  4. CS_n high after 5 bits -> no data_valid; next frame 8'h0F received cleanly with RX_Count=1.
//  5. Assert rst mid-byte -> outputs at reset values immediately; next frame 8'hFF decodes correctly.
//  6. Back-to-back frames, two clk cycles of CS_n high between them -> RX_Count restarts at 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI types and constants for spi_byte_receiver and spi_decoder.
// Holds the frame state encoding and the RX count width helper.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    localparam int BITS_PER_BYTE = 8;

    // Width needed to count 0..max_bytes without wrapping.
    function automatic int RX_COUNT_W(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/spi_byte_receiver_if.sv
// Byte-level link between spi_byte_receiver (master) and spi_decoder (slave).
// Carries the received byte strobe/count and the byte to transmit next.
interface spi_byte_receiver_if #(
    parameter int MAX_BYTES_PER_CS = 2
);
    import spi_pkg::*;

    localparam int CW = RX_COUNT_W(MAX_BYTES_PER_CS);

    logic [7:0]    tx_byte;
    logic          data_valid;
    logic [CW-1:0] RX_Count;
    logic [7:0]    rx_byte;

    modport master (
        input  tx_byte,
        output data_valid,
        output RX_Count,
        output rx_byte
    );

    modport slave (
        output tx_byte,
        input  data_valid,
        input  RX_Count,
        input  rx_byte
    );

endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one async SPI pin with rise/fall detect.
// Edges are derived from the last sync stage against a one-cycle history flop.
module spi_input_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    // Shift the pin through the sync chain and keep one cycle of history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_hist <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_hist;
    assign o_fall = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 peripheral front end: deserialises MOSI bytes, serialises MISO.
// Define SPI_OVERRUN_DETECT_EN to add o_overrun for bytes dropped in HOLD.
module spi_byte_receiver
    import spi_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int SYNC_STAGES      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_spi_sclk,
    input  logic i_spi_cs_n,
    input  logic i_spi_mosi,
    output logic o_spi_miso,
`ifdef SPI_OVERRUN_DETECT_EN
    output logic o_overrun,
`endif
    spi_byte_receiver_if.master bus
);

    localparam int CW = RX_COUNT_W(MAX_BYTES_PER_CS);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BYTES_PER_CS - 1);
    localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_BYTE - 1);

    logic w_sclk;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_n;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_mosi;

    logic [SYNC_STAGES-1:0] r_mosi_sync;

    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_rx_sh;
    logic [7:0]    r_tx_sh;
    logic [7:0]    r_rx_byte;
    logic [CW-1:0] r_rx_count;
    logic          r_data_valid;
    logic          r_miso;
`ifdef SPI_OVERRUN_DETECT_EN
    logic          r_overrun;
`endif

    spi_input_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_spi_sclk),
        .o_sync  (w_sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_input_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_spi_cs_n),
        .o_sync  (w_cs_n),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // MOSI only needs the same delay as SCLK so data lines up with its edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // Frame FSM: byte assembly, MISO shifting and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_rx_sh      <= '0;
            r_tx_sh      <= '0;
            r_rx_byte    <= '0;
            r_rx_count   <= '0;
            r_data_valid <= 1'b0;
            r_miso       <= 1'b0;
`ifdef SPI_OVERRUN_DETECT_EN
            r_overrun    <= 1'b0;
`endif
        end else begin
            r_data_valid <= 1'b0;
`ifdef SPI_OVERRUN_DETECT_EN
            r_overrun    <= 1'b0;
`endif
            if (w_cs_rise) begin
                // Deselect wins over everything; partial byte is dropped.
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // SCLK edges coincident with select are not sampled.
                        if (w_cs_fall) begin
                            r_state    <= SHIFT;
                            r_bit_cnt  <= '0;
                            r_rx_count <= '0;
                            r_tx_sh    <= {bus.tx_byte[6:0], 1'b0};
                            r_miso     <= bus.tx_byte[7];
                        end
                    end
                    SHIFT: begin
                        if (w_sclk_rise) begin
                            r_rx_sh <= {r_rx_sh[6:0], w_mosi};
                            if (r_bit_cnt == LAST_BIT) begin
                                r_rx_byte    <= {r_rx_sh[6:0], w_mosi};
                                r_data_valid <= 1'b1;
                                r_rx_count   <= r_rx_count + 1'b1;
                                r_bit_cnt    <= '0;
                                if (r_rx_count == LAST_CNT) begin
                                    r_state <= HOLD;
                                    r_miso  <= 1'b0;
                                end else begin
                                    // Full byte: next fall presents its MSB.
                                    r_tx_sh <= bus.tx_byte;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else if (w_sclk_fall) begin
                            r_miso  <= r_tx_sh[7];
                            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                        end
                    end
                    HOLD: begin
                        r_miso <= 1'b0;
`ifdef SPI_OVERRUN_DETECT_EN
                        // Track bit position only to flag dropped bytes.
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
                                r_overrun <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
`endif
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_spi_miso     = r_miso;
    assign bus.data_valid = r_data_valid;
    assign bus.RX_Count   = r_rx_count;
    assign bus.rx_byte    = r_rx_byte;
`ifdef SPI_OVERRUN_DETECT_EN
    assign o_overrun      = r_overrun;
`endif

    // Synchronised levels are kept for observability of the pin state.
    logic w_unused;
    assign w_unused = w_sclk ^ w_cs_n;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Scoreboard bench for spi_byte_receiver: SPI master stimulus, queued
// expectations, and a monitor that checks each data_valid pulse.
module tb_spi_byte_receiver;

    localparam int S    = 2;
    localparam int MAXB = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;
`ifdef SPI_OVERRUN_DETECT_EN
    logic overrun;
`endif

    spi_byte_receiver_if #(.MAX_BYTES_PER_CS(MAXB)) bus ();

    spi_byte_receiver #(
        .MAX_BYTES_PER_CS (MAXB),
        .SYNC_STAGES      (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_spi_sclk (sclk),
        .i_spi_cs_n (cs_n),
        .i_spi_mosi (mosi),
        .o_spi_miso (miso),
`ifdef SPI_OVERRUN_DETECT_EN
        .o_overrun  (overrun),
`endif
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         c;
        int         t;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;
    int ovr_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every data_valid pulse must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (bus.data_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=%0h required=none",
                             bus.rx_byte);
                end else begin
                    e = q.pop_front();
                    chk("rx_byte", int'(bus.rx_byte), int'(e.b));
                    chk("rx_count", int'(bus.RX_Count), e.c);
                    chk("latency", cyc - e.t, S + 1);
                end
            end
`ifdef SPI_OVERRUN_DETECT_EN
            if (overrun === 1'b1) ovr_seen++;
`endif
        end
    end

    task automatic start_frame(input logic [7:0] tx);
        bus.tx_byte = tx;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame(input int gap);
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits,
                             input logic [7:0] nxt, input bit pulse,
                             input int cnt, input logic [7:0] mexp,
                             input bit mchk);
        bus.tx_byte = nxt;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            mosi = b[i];
            repeat (3) @(negedge clk);
            @(negedge clk);
            sclk = 1'b1;
            if (mchk) chk("miso_bit", int'(miso), int'(mexp[i]));
            if (pulse && i == 0) q.push_back('{b, cnt, cyc});
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] nxt,
                             input bit pulse, input int cnt,
                             input logic [7:0] mexp, input bit mchk);
        send_bits(b, 8, nxt, pulse, cnt, mexp, mchk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dv"}, int'(bus.data_valid), 0);
        chk({tag, "_cnt"}, int'(bus.RX_Count), 0);
        chk({tag, "_rxb"}, int'(bus.rx_byte), 0);
        chk({tag, "_miso"}, int'(miso), 0);
    endtask

    initial begin
        bus.tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("post_rst");

        // Two bytes in one frame.
        start_frame(8'h00);
        send_byte(8'hAA, 8'h00, 1'b1, 1, 8'h00, 1'b0);
        send_byte(8'h6A, 8'h00, 1'b1, 2, 8'h00, 1'b0);
        end_frame(6);

        // MISO content for two slots.
        start_frame(8'hC3);
        send_byte(8'h12, 8'h5A, 1'b1, 1, 8'hC3, 1'b1);
        send_byte(8'h34, 8'h00, 1'b1, 2, 8'h5A, 1'b1);
        end_frame(6);

        // Third byte lands in HOLD: no pulse, MISO low.
        start_frame(8'h00);
        send_byte(8'h01, 8'h00, 1'b1, 1, 8'h00, 1'b0);
        send_byte(8'h02, 8'h00, 1'b1, 2, 8'h00, 1'b0);
        send_byte(8'h03, 8'hFF, 1'b0, 0, 8'h00, 1'b1);
        chk("hold_count", int'(bus.RX_Count), 2);
        chk("hold_rxb", int'(bus.rx_byte), 8'h02);
        end_frame(6);

        // Aborted partial byte, then a clean frame.
        start_frame(8'h00);
        send_bits(8'hF0, 5, 8'h00, 1'b0, 0, 8'h00, 1'b0);
        end_frame(6);
        start_frame(8'h00);
        send_byte(8'h0F, 8'h00, 1'b1, 1, 8'h00, 1'b0);
        end_frame(6);

        // Reset mid-byte.
        start_frame(8'hA5);
        send_bits(8'hE7, 3, 8'hA5, 1'b0, 0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        start_frame(8'h00);
        send_byte(8'hFF, 8'h00, 1'b1, 1, 8'h00, 1'b0);
        end_frame(2);

        // Back-to-back frames with a short deselect gap.
        start_frame(8'h00);
        send_byte(8'h3C, 8'h00, 1'b1, 1, 8'h00, 1'b0);
        end_frame(2);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        send_byte(8'h81, 8'h00, 1'b1, 1, 8'h00, 1'b0);
        end_frame(20);

        chk("pending_expect", q.size(), 0);
`ifdef SPI_OVERRUN_DETECT_EN
        chk("overrun_pulses", ovr_seen, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
